ascon_text_sequencer: RTL

ASCON_TEXT_SEQUENCER -- requirements
Module: ascon_text_sequencer

---
 rtl/ascon_pkg.sv | 33 +++
 rtl/ascon_text_sequencer_if.sv | 39 +++
 rtl/ascon_text_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// -----------------------------------------------------------------------------
// ascon_pkg
// Shared definitions for the ASCON text sequencer and its neighbours at the
// top level: block geometry, sequencer state encoding and the helper that
// turns a remaining byte count into the byte count of the next beat.
// -----------------------------------------------------------------------------
package ascon_pkg;

  // One text block is 128 bits. Byte 0 of a block sits in bits [127:120].
  localparam int unsigned BLOCK_BYTES = 16;
  localparam int unsigned BLOCK_BITS  = BLOCK_BYTES * 8;

  typedef logic [BLOCK_BITS-1:0] block_t;
  typedef logic [4:0]            bytes_t;   // 0..16 valid bytes per beat

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_FIRE    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_OUT     = 3'd4
  } seq_state_e;

  // min(remaining, BLOCK_BYTES). A remaining count of 0 yields 0, which is
  // how a zero-length job still produces its single, empty, final beat.
  function automatic bytes_t block_bytes(input logic [31:0] remaining);
    if (remaining > 32'(BLOCK_BYTES)) begin
      return bytes_t'(BLOCK_BYTES);
    end
    return remaining[4:0];
  endfunction

endpackage

// File: rtl/ascon_text_sequencer_if.sv
// -----------------------------------------------------------------------------
// ascon_text_sequencer_if
// Text streaming bus of the sequencer: an input block stream (in_*) and an
// output beat stream (out_*), both valid/ready handshakes. A transfer happens
// on a rising clock edge where valid and ready are both high.
//
//   in_valid  / in_ready  / in_data   : next 128-bit text block towards the core
//   out_valid / out_ready / out_data  : processed 128-bit block
//   out_bytes                         : number of valid bytes in out_data (0..16)
//   out_last                          : final beat of the job
//
// Modports:
//   slave  - the sequencer (consumes in_*, produces out_*)
//   master - the surrounding system (produces in_*, consumes out_*)
// -----------------------------------------------------------------------------
interface ascon_text_sequencer_if;
  import ascon_pkg::*;

  logic   in_valid;
  logic   in_ready;
  block_t in_data;

  logic   out_valid;
  logic   out_ready;
  block_t out_data;
  bytes_t out_bytes;
  logic   out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_bytes, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_bytes, out_last
  );

endinterface

// File: rtl/ascon_text_sequencer.sv
// -----------------------------------------------------------------------------
// ascon_text_sequencer
// Walks a text of 'length' bytes through an ASCON encrypt/decrypt core one
// 16-byte block at a time. Per block: LOAD takes a block from the input
// stream, FIRE pulses process_en to the core, CAPTURE takes the core result
// (registered by the core one cycle after process_en), OUT presents it on the
// output stream until accepted. A job always issues ceil(length/16) blocks,
// with a minimum of one (a zero-length job emits one empty final beat).
//
// The core itself lives next to this block at the top level; its x0..x4
// state chaining is wired there and does not pass through here.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              one-cycle pulse, begins a job (ignored unless idle)
//   mode               0 encrypt, 1 decrypt (latched at start)
//   length             text length in bytes (latched at start)
//   abort              cancels the current job, back to idle next cycle
//   bus                text streams (slave side)
//   process_en         one-cycle strobe to the core
//   process_mode_sel   latched mode for the core
//   text_length        latched length for the core
//   text_position      byte offset of the current block
//   data_in            current text block for the core
//   data_out           core result, valid the cycle after process_en
//   process_err        core error, sampled while process_en is high
//   busy               high whenever a job is in progress
//   done               one-cycle pulse when the last beat is accepted
//   err                one-cycle pulse when the core reports an error
// -----------------------------------------------------------------------------
module ascon_text_sequencer
  import ascon_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,

  input  logic                         start,
  input  logic                         mode,
  input  logic [31:0]                  length,
  input  logic                         abort,

  ascon_text_sequencer_if.slave        bus,

  output logic                         process_en,
  output logic                         process_mode_sel,
  output logic [31:0]                  text_length,
  output logic [31:0]                  text_position,
  output block_t                       data_in,
  input  block_t                       data_out,
  input  logic                         process_err,

  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  seq_state_e  state_q;

  // Job registers: fixed for the whole job.
  logic        mode_q;
  logic [31:0] length_q;
  logic [31:0] position_q;

  // Block registers.
  block_t      data_in_q;
  block_t      out_data_q;
  bytes_t      out_bytes_q;
  logic        out_last_q;

  // Registered control outputs.
  logic        in_ready_q;
  logic        out_valid_q;
  logic        process_en_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;

  // Geometry of the block at position_q. position_q never passes length_q,
  // so the unsigned 32-bit difference never wraps.
  logic [31:0] remaining_d;
  bytes_t      out_bytes_d;
  logic        out_last_d;

  // NOTE: an always_comb block must assign every output on every path; a
  // missed assignment would infer a latch. Here each signal is written
  // unconditionally.
  always_comb begin
    remaining_d = length_q - position_q;
    out_bytes_d = block_bytes(remaining_d);
    out_last_d  = (remaining_d <= 32'(BLOCK_BYTES));
  end

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples values from before the edge, independent of the order
  // of statements below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data-path registers (data_in, out_data, job registers) are
      // reset too, not just the control state, because they drive outputs
      // that must read zero during and after reset.
      state_q      <= ST_IDLE;
      mode_q       <= 1'b0;
      length_q     <= '0;
      position_q   <= '0;
      data_in_q    <= '0;
      out_data_q   <= '0;
      out_bytes_q  <= '0;
      out_last_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      process_en_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // Pulses default low and are raised only on the transition that
      // causes them.
      done_q <= 1'b0;
      err_q  <= 1'b0;

      if (abort && (state_q != ST_IDLE)) begin
        // Abort beats every other event, including an output handshake or a
        // core error in the same cycle: no done, no err.
        state_q      <= ST_IDLE;
        in_ready_q   <= 1'b0;
        out_valid_q  <= 1'b0;
        process_en_q <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start) begin
              mode_q     <= mode;
              length_q   <= length;
              position_q <= '0;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= ST_LOAD;
            end
          end

          ST_LOAD: begin
            if (bus.in_valid) begin
              data_in_q    <= bus.in_data;
              in_ready_q   <= 1'b0;
              process_en_q <= 1'b1;
              state_q      <= ST_FIRE;
            end
          end

          ST_FIRE: begin
            // process_en is high for exactly this one cycle.
            process_en_q <= 1'b0;
            if (process_err) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_CAPTURE;
            end
          end

          ST_CAPTURE: begin
            // The core registered its result at the end of FIRE.
            out_data_q  <= data_out;
            out_bytes_q <= out_bytes_d;
            out_last_q  <= out_last_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_OUT;
          end

          ST_OUT: begin
            if (bus.out_ready) begin
              out_valid_q <= 1'b0;
              if (out_last_q) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end else begin
                position_q <= position_q + 32'(BLOCK_BYTES);
                in_ready_q <= 1'b1;
                state_q    <= ST_LOAD;
              end
            end
          end

          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_bytes     = out_bytes_q;
  assign bus.out_last      = out_last_q;

  assign process_en        = process_en_q;
  assign process_mode_sel  = mode_q;
  assign text_length       = length_q;
  assign text_position     = position_q;
  assign data_in           = data_in_q;

  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;

endmodule
